bus_read_sequencer: RTL and testbench

- Synchronous bus master for sEP8 memory reads: drives a23_a0, s_ and mr_ toward ROM/RAM and samples d7_d0.
- Assembles 1–3 consecutive bytes, little-endian, into one word. Serves instruction/operand fetch, e.g. opcode, 8-bit immediate, 24-bit jump target.
- Sits directly upstream of the memory modules; consumer is the sEP8 control unit.

---
 rtl/bus_read_sequencer.sv | 148 ++++++++++++++
 tb/tb_bus_read_sequencer.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/bus_read_sequencer.sv
// bus_read_sequencer: reads 1-3 consecutive bytes from the memory bus and
// assembles them little-endian into one 24-bit word. It drives the address,
// the select strobe and the read strobe, and samples d7_d0 once per byte
// after a programmable number of wait cycles.
module bus_read_sequencer #(
    parameter int unsigned WAIT_CYCLES = 2    // legal range 0..15
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [23:0] addr,
    input  logic [1:0]  nbytes,
    output logic [23:0] a23_a0,
    output logic        s_,
    output logic        mr_,
    input  logic [7:0]  d7_d0,
    output logic [23:0] dato,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES);

    state_t      state_q, state_d;
    logic [1:0]  nbytes_q, nbytes_d;
    logic [1:0]  idx_q, idx_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [23:0] addr_d;
    logic [23:0] dato_d;
    logic        strobe_n_q, strobe_n_d;
    logic        busy_d;
    logic        done_d;
    logic [1:0]  last_idx;

    // Index of the final byte of the current request.
    assign last_idx = nbytes_q - 2'd1;

    // Select and read strobe come from one flop so they can never diverge.
    assign s_  = strobe_n_q;
    assign mr_ = strobe_n_q;

    // Register every piece of state; reset returns the bus to quiet idle.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values computed by the combinational block.
        if (reset) begin
            state_q    <= IDLE;
            nbytes_q   <= 2'd0;
            idx_q      <= 2'd0;
            cnt_q      <= 4'd0;
            a23_a0     <= 24'h000000;
            dato       <= 24'h000000;
            strobe_n_q <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state_q    <= state_d;
            nbytes_q   <= nbytes_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            a23_a0     <= addr_d;
            dato       <= dato_d;
            strobe_n_q <= strobe_n_d;
            busy       <= busy_d;
            done       <= done_d;
        end
    end

    // Next-state and next-output logic for the IDLE / READ / GAP sequence.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one
        // unassigned, which would otherwise infer a latch.
        state_d    = state_q;
        nbytes_d   = nbytes_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        addr_d     = a23_a0;
        dato_d     = dato;
        strobe_n_d = strobe_n_q;
        busy_d     = busy;
        done_d     = 1'b0;

        case (state_q)
            IDLE: begin
                // A start coinciding with the done pulse is dropped, not queued.
                if (start && !done) begin
                    dato_d = 24'h000000;
                    if (nbytes != 2'd0) begin
                        nbytes_d   = nbytes;
                        addr_d     = addr;
                        idx_d      = 2'd0;
                        cnt_d      = 4'd0;
                        strobe_n_d = 1'b0;
                        busy_d     = 1'b1;
                        state_d    = READ;
                    end else begin
                        // Null request: complete immediately, no bus cycle.
                        done_d = 1'b1;
                    end
                end
            end

            READ: begin
                if (cnt_q == WAIT_LAST) begin
                    // Capture edge: data bus is only looked at here.
                    case (idx_q)
                        2'd0:    dato_d[7:0]   = d7_d0;
                        2'd1:    dato_d[15:8]  = d7_d0;
                        2'd2:    dato_d[23:16] = d7_d0;
                        default: dato_d        = dato;
                    endcase
                    strobe_n_d = 1'b1;
                    if (idx_q == last_idx) begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = GAP;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end

            GAP: begin
                // One strobe-high cycle with the address held, then next byte.
                addr_d     = a23_a0 + 24'd1;
                idx_d      = idx_q + 2'd1;
                cnt_d      = 4'd0;
                strobe_n_d = 1'b0;
                state_d    = READ;
            end

            default: begin
                state_d    = IDLE;
                strobe_n_d = 1'b1;
                busy_d     = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_bus_read_sequencer.sv
// Self-checking bench for bus_read_sequencer: two instances (WAIT_CYCLES=2
// and 0), a delayed memory model per instance, and a scoreboard of expected
// assembled words popped on each done pulse.
module tb_bus_read_sequencer;

    localparam int W0 = 2;
    localparam int W1 = 0;

    logic        clock = 1'b0;
    logic        reset;

    logic        start_0, start_1;
    logic [23:0] addr_0, addr_1;
    logic [1:0]  nb_0, nb_1;
    logic [23:0] a_0, a_1;
    logic        s_0, s_1, mr_0, mr_1;
    logic [7:0]  d_0, d_1;
    logic [23:0] dato_0, dato_1;
    logic        busy_0, busy_1, done_0, done_1;

    int vectors     = 0;
    int miscompares = 0;

    logic [23:0] exp_q0[$];
    logic [23:0] exp_q1[$];

    // Snapshot of the instance under test.
    logic        s_v, mr_v, busy_v, done_v;
    logic [23:0] a_v, dato_v;

    always #5 clock = ~clock;

    bus_read_sequencer #(.WAIT_CYCLES(W0)) dut0 (
        .clock(clock), .reset(reset), .start(start_0), .addr(addr_0),
        .nbytes(nb_0), .a23_a0(a_0), .s_(s_0), .mr_(mr_0), .d7_d0(d_0),
        .dato(dato_0), .busy(busy_0), .done(done_0)
    );

    bus_read_sequencer #(.WAIT_CYCLES(W1)) dut1 (
        .clock(clock), .reset(reset), .start(start_1), .addr(addr_1),
        .nbytes(nb_1), .a23_a0(a_1), .s_(s_1), .mr_(mr_1), .d7_d0(d_1),
        .dato(dato_1), .busy(busy_1), .done(done_1)
    );

    function automatic logic [7:0] mem_rd(input logic [23:0] a);
        case (a)
            24'hFF0002: return 8'h41;
            24'hFF000B: return 8'h03;
            24'hFF000C: return 8'h00;
            24'hFF000D: return 8'hFF;
            24'hFFFFFF: return 8'h5A;
            24'h000000: return 8'hA5;
            default:    return 8'hEE;
        endcase
    endfunction

    // Memory models: data appears 2 ns after a strobed address, Z otherwise.
    always @(a_0 or s_0 or mr_0) begin
        #2;
        d_0 = (!s_0 && !mr_0) ? mem_rd(a_0) : 8'hzz;
    end

    always @(a_1 or s_1 or mr_1) begin
        #2;
        d_1 = (!s_1 && !mr_1) ? mem_rd(a_1) : 8'hzz;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard: every done pulse pops one expected word.
    always @(negedge clock) begin
        if (done_0 === 1'b1) begin
            if (exp_q0.size() == 0) check("dut0 unexpected done", 32'd1, 32'd0);
            else check("dut0 scoreboard dato", {8'h00, dato_0}, {8'h00, exp_q0.pop_front()});
        end
        if (done_1 === 1'b1) begin
            if (exp_q1.size() == 0) check("dut1 unexpected done", 32'd1, 32'd0);
            else check("dut1 scoreboard dato", {8'h00, dato_1}, {8'h00, exp_q1.pop_front()});
        end
    end

    task automatic snap(input int d);
        if (d == 0) begin
            s_v = s_0; mr_v = mr_0; busy_v = busy_0; done_v = done_0; a_v = a_0; dato_v = dato_0;
        end else begin
            s_v = s_1; mr_v = mr_1; busy_v = busy_1; done_v = done_1; a_v = a_1; dato_v = dato_1;
        end
    endtask

    task automatic drive(input int d, input logic st, input logic [23:0] ad, input logic [1:0] nb);
        if (d == 0) begin
            start_0 = st; addr_0 = ad; nb_0 = nb;
        end else begin
            start_1 = st; addr_1 = ad; nb_1 = nb;
        end
    endtask

    // One request; cycle c is the state after edge c (edge 0 accepts start).
    task automatic run_read(input int d, input logic [23:0] ad, input logic [1:0] nb,
                            input logic [23:0] exp_dato, input bit inject);
        int          w, done_c, lows, dones, first_done;
        bit          pair_ok, busy_ok, hold_ok;
        logic [23:0] seq[$];
        w          = (d == 0) ? W0 : W1;
        done_c     = (nb == 2'd0) ? 0 : int'(nb) * (w + 2) - 1;
        lows       = 0;
        dones      = 0;
        first_done = -1;
        pair_ok    = 1'b1;
        busy_ok    = 1'b1;
        hold_ok    = 1'b1;
        @(negedge clock);
        drive(d, 1'b1, ad, nb);
        if (d == 0) exp_q0.push_back(exp_dato); else exp_q1.push_back(exp_dato);
        for (int c = 0; c <= done_c + 3; c++) begin
            @(negedge clock);
            snap(d);
            if (s_v !== mr_v) pair_ok = 1'b0;
            if (s_v === 1'b0) begin
                lows++;
                if (seq.size() == 0 || a_v !== seq[$]) seq.push_back(a_v);
            end else if (busy_v === 1'b1 && seq.size() > 0 && a_v !== seq[$]) begin
                hold_ok = 1'b0;
            end
            if (busy_v !== logic'(c < done_c)) busy_ok = 1'b0;
            if (done_v === 1'b1) begin
                dones++;
                if (first_done < 0) first_done = c;
            end
            // Optional ignored starts: while busy, and in the done cycle.
            if (inject && ((c >= 1 && c <= 4) || c == done_c))
                drive(d, 1'b1, 24'hFF0002, 2'd1);
            else
                drive(d, 1'b0, ad, nb);
        end
        check($sformatf("d%0d %h strobe-low cycles", d, ad), lows, int'(nb) * (w + 1));
        check($sformatf("d%0d %h done cycle", d, ad), first_done, done_c);
        check($sformatf("d%0d %h done pulses", d, ad), dones, 1);
        check($sformatf("d%0d %h busy window", d, ad), {31'd0, busy_ok}, 32'd1);
        check($sformatf("d%0d %h s_/mr_ together", d, ad), {31'd0, pair_ok}, 32'd1);
        check($sformatf("d%0d %h address count", d, ad), seq.size(), int'(nb));
        for (int i = 0; i < seq.size(); i++)
            check($sformatf("d%0d %h address %0d", d, ad, i), {8'h00, seq[i]}, {8'h00, 24'(ad + 24'(i))});
        check($sformatf("d%0d %h address held in gap", d, ad), {31'd0, hold_ok}, 32'd1);
        check($sformatf("d%0d %h dato held", d, ad), {8'h00, dato_v}, {8'h00, exp_dato});
        if (seq.size() > 0)
            check($sformatf("d%0d %h idle address held", d, ad), {8'h00, a_v}, {8'h00, seq[$]});
    endtask

    initial begin
        reset = 1'b1;
        drive(0, 1'b0, 24'h0, 2'd0);
        drive(1, 1'b0, 24'h0, 2'd0);
        repeat (3) @(negedge clock);
        for (int d = 0; d < 2; d++) begin
            snap(d);
            check($sformatf("d%0d reset s_", d), {31'd0, s_v}, 32'd1);
            check($sformatf("d%0d reset mr_", d), {31'd0, mr_v}, 32'd1);
            check($sformatf("d%0d reset a23_a0", d), {8'h00, a_v}, 32'd0);
            check($sformatf("d%0d reset dato", d), {8'h00, dato_v}, 32'd0);
            check($sformatf("d%0d reset busy", d), {31'd0, busy_v}, 32'd0);
            check($sformatf("d%0d reset done", d), {31'd0, done_v}, 32'd0);
        end
        reset = 1'b0;

        run_read(0, 24'hFF0002, 2'd1, 24'h000041, 1'b0);
        run_read(0, 24'hFF000B, 2'd3, 24'hFF0003, 1'b1);
        run_read(0, 24'hFFFFFF, 2'd2, 24'h00A55A, 1'b0);
        run_read(0, 24'h123456, 2'd0, 24'h000000, 1'b0);
        snap(0);
        check("d0 null request keeps address", {8'h00, a_v}, 32'h000000);

        // Reset applied at edge 5 of a 3-byte read aborts it without done.
        @(negedge clock);
        drive(0, 1'b1, 24'hFF000B, 2'd3);
        for (int c = 0; c <= 5; c++) begin
            @(negedge clock);
            snap(0);
            drive(0, 1'b0, 24'hFF000B, 2'd3);
            if (c == 4) begin
                check("d0 pre-reset first byte", {8'h00, dato_v}, 32'h000003);
                check("d0 pre-reset strobe low", {31'd0, s_v}, 32'd0);
            end
            if (c == 5) begin
                check("d0 abort s_", {31'd0, s_v}, 32'd1);
                check("d0 abort mr_", {31'd0, mr_v}, 32'd1);
                check("d0 abort busy", {31'd0, busy_v}, 32'd0);
                check("d0 abort dato", {8'h00, dato_v}, 32'd0);
                check("d0 abort done", {31'd0, done_v}, 32'd0);
            end
            reset = (c == 4);
        end
        run_read(0, 24'hFF000B, 2'd3, 24'hFF0003, 1'b0);

        run_read(1, 24'hFF000B, 2'd2, 24'h000003, 1'b0);

        repeat (2) @(negedge clock);
        check("d0 scoreboard drained", exp_q0.size(), 0);
        check("d1 scoreboard drained", exp_q1.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
